// File: rtl/backprop_accumulator.sv
// backprop_accumulator: sums FANOUT signed backprop-change terms with
// saturation and hands the result to the upstream neuron over valid/ready.
module backprop_accumulator #(
    parameter int unsigned FANOUT = 4,
    parameter int unsigned WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_change,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_backprop,
    output logic             out_sat,
    output logic             busy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FANOUT);
    localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [WIDTH-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic               acc_sat, acc_sat_n;
    logic [WIDTH-1:0]   res, res_n;
    logic               res_sat, res_sat_n;

    logic               in_fire;
    logic               out_fire;
    logic [WIDTH-1:0]   sum_raw;
    logic               sum_ovf;
    logic [WIDTH-1:0]   sum_sat;
    logic [CNT_W-1:0]   cnt_inc;

    // Handshake: in HOLD the input is only taken when the result leaves.
    assign in_ready  = !rst && ((state == ACCUM) || out_ready);
    assign out_valid = (state == HOLD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_backprop = res;
    assign out_sat      = res_sat;
    assign busy         = (cnt != '0) || (state == HOLD);

    // Saturating signed add of the incoming term onto the running sum.
    always_comb begin
        sum_raw = acc + in_change;
        sum_ovf = (acc[WIDTH-1] == in_change[WIDTH-1]) &&
                  (sum_raw[WIDTH-1] != acc[WIDTH-1]);
        sum_sat = sum_ovf ? (acc[WIDTH-1] ? MIN_VAL : MAX_VAL) : sum_raw;
        cnt_inc = cnt + CNT_W'(1);
    end

    // Next-state: acc/cnt are already clear in HOLD, so a term accepted
    // alongside an output transfer simply starts the next sum.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        cnt_n     = cnt;
        acc_sat_n = acc_sat;
        res_n     = res;
        res_sat_n = res_sat;

        if (out_fire) begin
            state_n   = ACCUM;
            res_n     = '0;
            res_sat_n = 1'b0;
        end

        if (in_fire) begin
            if (cnt_inc == LAST_CNT) begin
                state_n   = HOLD;
                res_n     = sum_sat;
                res_sat_n = acc_sat || sum_ovf;
                acc_n     = '0;
                cnt_n     = '0;
                acc_sat_n = 1'b0;
            end else begin
                acc_n     = sum_sat;
                cnt_n     = cnt_inc;
                acc_sat_n = acc_sat || sum_ovf;
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            acc_sat <= 1'b0;
            res     <= '0;
            res_sat <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            acc_sat <= acc_sat_n;
            res     <= res_n;
            res_sat <= res_sat_n;
        end
    end

endmodule

// File: tb/tb_backprop_accumulator.sv
// Self-checking bench for backprop_accumulator (FANOUT=4 and FANOUT=1).
module tb_backprop_accumulator;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, out_sat, busy;
    logic [31:0] in_change, out_backprop;

    logic        f1_in_valid, f1_in_ready, f1_out_valid, f1_out_ready, f1_out_sat, f1_busy;
    logic [31:0] f1_in_change, f1_out_backprop;

    int checks = 0;
    int errors = 0;

    backprop_accumulator #(.FANOUT(4), .WIDTH(32)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_change(in_change),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_backprop(out_backprop), .out_sat(out_sat), .busy(busy)
    );

    backprop_accumulator #(.FANOUT(1), .WIDTH(32)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(f1_in_valid), .in_ready(f1_in_ready), .in_change(f1_in_change),
        .out_valid(f1_out_valid), .out_ready(f1_out_ready),
        .out_backprop(f1_out_backprop), .out_sat(f1_out_sat), .busy(f1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the falling edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic v, input logic [31:0] d, input logic r);
        in_valid  = v;
        in_change = d;
        out_ready = r;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference: saturating sum over a complete list of terms.
    function automatic void fold(input logic [31:0] t[$], output logic [31:0] r,
                                 output logic s);
        longint a;
        a = 0;
        s = 1'b0;
        foreach (t[i]) begin
            a = a + longint'($signed(t[i]));
            if (a > 64'sd2147483647) begin a = 64'sd2147483647; s = 1'b1; end
            if (a < -64'sd2147483648) begin a = -64'sd2147483648; s = 1'b1; end
        end
        r = 32'(a);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_change = 32'd55; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_backprop !== 32'd0 || out_sat !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%h s=%b b=%b want 0 0 0 0",
                     out_valid, out_backprop, out_sat, busy);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_basic_sum();
        put(1'b1, 32'd10, 1'b1);
        put(1'b1, -32'sd3, 1'b1);
        put(1'b1, 32'd7, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || out_backprop !== 32'd0) begin
            errors++;
            $display("FAIL basic_partial got v=%b b=%b d=%h want 0 1 0", out_valid, busy, out_backprop);
        end
        put(1'b1, 32'd1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_backprop !== 32'd15 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got v=%b d=%0d s=%b want 1 15 0", out_valid, $signed(out_backprop), out_sat);
        end
        put(1'b0, 32'hDEAD_BEEF, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_backprop !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got v=%b d=%h b=%b want 0 0 0", out_valid, out_backprop, busy);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) put(1'b1, 32'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_change = 32'd9; out_ready = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_backprop !== 32'd20 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable got v=%b d=%0d rdy=%b want 1 20 0",
                         out_valid, out_backprop, in_ready);
            end
            tick();
        end
        in_valid = 1'b1; in_change = 32'd9; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_pass_ready got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overlap_start got v=%b b=%b want 0 1", out_valid, busy);
        end
        for (int i = 0; i < 3; i++) put(1'b1, 32'd1, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_backprop !== 32'd12 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL overlap_result got v=%b d=%0d s=%b want 1 12 0", out_valid, out_backprop, out_sat);
        end
        put(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_saturation();
        put(1'b1, 32'h7FFF_FFF0, 1'b1);
        put(1'b1, 32'h0000_0100, 1'b1);
        put(1'b1, 32'h8000_0000, 1'b1);
        put(1'b1, 32'h0000_0000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_backprop !== 32'hFFFF_FFFF || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got v=%b d=%h s=%b want 1 ffffffff 1", out_valid, out_backprop, out_sat);
        end
        put(1'b1, 32'h8000_0001, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear got v=%b s=%b want 0 0", out_valid, out_sat);
        end
        put(1'b1, 32'hFFFF_FF00, 1'b1);
        put(1'b1, 32'h0, 1'b1);
        put(1'b1, 32'h0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_backprop !== 32'h8000_0000 || out_sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg got v=%b d=%h s=%b want 1 80000000 1", out_valid, out_backprop, out_sat);
        end
        put(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_gaps();
        put(1'b1, 32'd3, 1'b1);
        put(1'b0, 32'd999, 1'b1);
        put(1'b1, 32'd4, 1'b1);
        put(1'b0, 32'hFFFF_0000, 1'b1);
        put(1'b0, 32'd7, 1'b1);
        put(1'b1, 32'd5, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_partial got v=%b b=%b want 0 1", out_valid, busy);
        end
        put(1'b1, 32'd6, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_backprop !== 32'd18) begin
            errors++;
            $display("FAIL gap_result got v=%b d=%0d want 1 18", out_valid, out_backprop);
        end
        put(1'b0, 32'd0, 1'b1);
    endtask

    task automatic test_reset_mid();
        put(1'b1, 32'd100, 1'b1);
        put(1'b1, 32'd200, 1'b1);
        in_valid = 1'b0;
        do_reset();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_busy got b=%b v=%b want 0 0", busy, out_valid);
        end
        put(1'b1, 32'd1, 1'b1);
        put(1'b1, 32'd2, 1'b1);
        put(1'b1, 32'd3, 1'b1);
        put(1'b1, 32'd4, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_backprop !== 32'd10 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_result got v=%b d=%0d s=%b want 1 10 0", out_valid, out_backprop, out_sat);
        end
        for (int i = 0; i < 4; i++) put(1'b1, 32'd8, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || out_backprop !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got v=%b d=%h b=%b want 0 0 0", out_valid, out_backprop, busy);
        end
    endtask

    task automatic test_fanout1();
        f1_in_valid = 1'b1; f1_out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            f1_in_change = 32'(i);
            tick();
            checks++;
            if (f1_out_valid !== 1'b1 || f1_out_backprop !== 32'(i) || f1_out_sat !== 1'b0) begin
                errors++;
                $display("FAIL fanout1_stream got v=%b d=%0d s=%b want 1 %0d 0",
                         f1_out_valid, f1_out_backprop, f1_out_sat, i);
            end
        end
        f1_in_valid = 1'b0;
        tick();
        checks++;
        if (f1_out_valid !== 1'b0 || f1_busy !== 1'b0) begin
            errors++;
            $display("FAIL fanout1_drain got v=%b b=%b want 0 0", f1_out_valid, f1_busy);
        end
    endtask

    // Random traffic against a term-list model with occasional resets.
    task automatic test_random();
        logic [31:0] terms[$];
        logic        m_hold;
        logic [31:0] m_res;
        logic        m_sat;
        logic        v, r, rs, exp_rdy, in_f, out_f;
        logic [31:0] d;
        do_reset();
        m_hold = 1'b0; m_res = '0; m_sat = 1'b0; terms.delete();
        for (int c = 0; c < 600; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 60) == 0);
            case ($urandom_range(0, 3))
                0:       d = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
                1:       d = 32'h8000_0000 + 32'($urandom_range(0, 65535));
                2:       d = $urandom;
                default: d = 32'($urandom_range(0, 400)) - 32'd200;
            endcase
            in_valid = v; in_change = d; out_ready = r; rst = rs;
            #1;
            exp_rdy = !rs && (!m_hold || r);
            checks++;
            if (in_ready !== exp_rdy || out_valid !== m_hold ||
                out_backprop !== (m_hold ? m_res : 32'd0) ||
                out_sat !== (m_hold && m_sat) ||
                busy !== (m_hold || terms.size() != 0)) begin
                errors++;
                $display("FAIL random c=%0d got rdy=%b v=%b d=%h s=%b b=%b want %b %b %h %b %b",
                         c, in_ready, out_valid, out_backprop, out_sat, busy,
                         exp_rdy, m_hold, m_hold ? m_res : 32'd0, m_hold && m_sat,
                         m_hold || terms.size() != 0);
            end
            tick();
            if (rs) begin
                m_hold = 1'b0; m_res = '0; m_sat = 1'b0; terms.delete();
            end else begin
                in_f  = v && exp_rdy;
                out_f = m_hold && r;
                if (out_f) m_hold = 1'b0;
                if (in_f) begin
                    terms.push_back(d);
                    if (terms.size() == 4) begin
                        fold(terms, m_res, m_sat);
                        terms.delete();
                        m_hold = 1'b1;
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_change = '0; out_ready = 1'b0;
        f1_in_valid = 1'b0; f1_in_change = '0; f1_out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_sum();
        test_backpressure();
        test_saturation();
        test_gaps();
        test_reset_mid();
        test_fanout1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
